// File: rtl/mux_sel_arbiter_pkg.sv
// Types for the 2:1 mux arbiter, built on the shared encodings in mux_defs.vh.
package mux_sel_arbiter_pkg;

    `include "mux_defs.vh"

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GNT_A = ST_GNT_A,
        GNT_B = ST_GNT_B
    } state_t;

    // Which source wins the next simultaneous request from IDLE.
    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

endpackage

// File: rtl/hold_counter.sv
// Saturating up-counter: load1 restarts at 1, inc counts up to SAT, neither clears to 0.
module hold_counter #(
    parameter int CNT_W = 3,
    parameter int SAT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load1,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load1) begin
            count <= CNT_W'(1);
        end else if (inc) begin
            if (count != CNT_W'(SAT)) begin
                count <= count + CNT_W'(1);
            end
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/mux_defs.vh
// Shared encodings for the mux control path: FSM state codes and mux select values.
`ifndef MUX_DEFS_VH
`define MUX_DEFS_VH

localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_GNT_A = 2'd1;
localparam logic [1:0] ST_GNT_B = 2'd2;

localparam logic SEL_A = 1'b0;
localparam logic SEL_B = 1'b1;

`endif

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter with bounded hold time driving sel/en of a 2:1 mux.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    output logic             sel,
    output logic             en,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [CNT_W-1:0] hold_cnt
);

    state_t state;
    state_t next_state;
    prio_t  prio;
    logic   timeout;
    logic   new_grant;
    logic   cnt_inc;

    assign timeout = (hold_cnt == CNT_W'(HOLD_CYCLES));

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    next_state = (prio == PRIO_A) ? GNT_A : GNT_B;
                end else if (req_a) begin
                    next_state = GNT_A;
                end else if (req_b) begin
                    next_state = GNT_B;
                end
            end
            GNT_A: begin
                if (!req_a) begin
                    next_state = req_b ? GNT_B : IDLE;
                end else if (req_b && timeout) begin
                    next_state = GNT_B;
                end
            end
            GNT_B: begin
                if (!req_b) begin
                    next_state = req_a ? GNT_A : IDLE;
                end else if (req_a && timeout) begin
                    next_state = GNT_A;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A grant is new whenever the owner changes, including a direct A<->B switch.
    assign new_grant = (next_state != IDLE) && (next_state != state);
    assign cnt_inc   = (next_state != IDLE) && !new_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            prio  <= PRIO_A;
            sel   <= SEL_A;
            en    <= 1'b0;
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
        end else begin
            state <= next_state;
            gnt_a <= (next_state == GNT_A);
            gnt_b <= (next_state == GNT_B);
            en    <= (next_state == GNT_A) || (next_state == GNT_B);
            // sel only moves on a grant; IDLE keeps the mux steady.
            if (next_state == GNT_A) begin
                sel <= SEL_A;
            end else if (next_state == GNT_B) begin
                sel <= SEL_B;
            end
            if (new_grant) begin
                prio <= (next_state == GNT_A) ? PRIO_B : PRIO_A;
            end
        end
    end

    hold_counter #(
        .CNT_W (CNT_W),
        .SAT   (HOLD_CYCLES)
    ) u_hold_counter (
        .clk   (clk),
        .rst   (rst),
        .load1 (new_grant),
        .inc   (cnt_inc),
        .count (hold_cnt)
    );

endmodule
